// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM state encoding and the default bit period
// used by both the receiver and the transmitter.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_t;

  localparam int CLK_PER_BIT_DEF = 2604;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO; pointers carry one extra wrap bit
// so full and empty are told apart by the MSB compare.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot, so a full FIFO still takes the push.
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

  assign dout = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receiver: synchronizes RX, decodes start/data/parity/stop with a baud
// counter, and queues good frames into a small FIFO with sticky error flags.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int CLK_PER_BIT = CLK_PER_BIT_DEF,
  parameter int DATA_BITS   = 8,
  parameter int PARITY_EN   = 0,
  parameter int PARITY_ODD  = 0,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 RX,
  input  logic                 rd_en,
  input  logic                 err_clr,
  output logic [DATA_BITS-1:0] cmd,
  output logic                 rdy,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun
);

  localparam int            CW       = $clog2(CLK_PER_BIT);
  localparam int            BW       = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLK_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(CLK_PER_BIT / 2 - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

  function automatic logic parity_bad(input logic [DATA_BITS-1:0] d, input logic p);
    return ((^d) ^ p) != 1'(PARITY_ODD);
  endfunction

  logic rx_s1;
  logic rxs;
  logic rxs_d;

  rx_state_t            state, state_nx;
  logic [CW-1:0]        cnt, cnt_nx;
  logic [BW-1:0]        bit_cnt, bit_cnt_nx;
  logic [DATA_BITS-1:0] shift, shift_nx;
  logic                 par_bit, par_bit_nx;
  logic                 push_req;
  logic                 frame_set;
  logic                 parity_set;
  logic                 overrun_set;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 pop;

  // Synchronizer stage; rxs_d holds the previous rxs for falling-edge detect.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_s1 <= 1'b1;
      rxs   <= 1'b1;
      rxs_d <= 1'b1;
    end else begin
      rx_s1 <= RX;
      rxs   <= rx_s1;
      rxs_d <= rxs;
    end
  end

  // Frame decoder state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_cnt <= '0;
      shift   <= '0;
      par_bit <= 1'b0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      bit_cnt <= bit_cnt_nx;
      shift   <= shift_nx;
      par_bit <= par_bit_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    cnt_nx     = (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
    bit_cnt_nx = bit_cnt;
    shift_nx   = shift;
    par_bit_nx = par_bit;
    push_req   = 1'b0;
    frame_set  = 1'b0;
    parity_set = 1'b0;
    case (state)
      IDLE: begin
        cnt_nx     = '0;
        bit_cnt_nx = '0;
        if (rxs_d && !rxs) state_nx = START;
      end
      START: begin
        if (cnt == CNT_HALF) begin
          cnt_nx   = '0;
          state_nx = rxs ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt == CNT_LAST) begin
          shift_nx   = {rxs, shift[DATA_BITS-1:1]};
          bit_cnt_nx = bit_cnt + 1'b1;
          if (bit_cnt == BIT_LAST) state_nx = (PARITY_EN != 0) ? PARITY : STOP;
        end
      end
      PARITY: begin
        if (cnt == CNT_LAST) begin
          par_bit_nx = rxs;
          state_nx   = STOP;
        end
      end
      STOP: begin
        // A low stop bit returns to IDLE with rxs still low, so a break cannot
        // restart until the line goes high and falls again.
        if (cnt == CNT_LAST) begin
          state_nx = IDLE;
          if (!rxs)                                          frame_set  = 1'b1;
          else if ((PARITY_EN != 0) && parity_bad(shift, par_bit)) parity_set = 1'b1;
          else                                               push_req   = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign pop         = rd_en && !fifo_empty;
  assign overrun_set = push_req && fifo_full && !pop;

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_req),
    .pop   (pop),
    .din   (shift),
    .dout  (cmd),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign rdy = !fifo_empty;

  // Sticky flags: a new error in the clearing cycle takes priority.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      frame_err  <= frame_set   | (frame_err  & ~err_clr);
      parity_err <= parity_set  | (parity_err & ~err_clr);
      overrun    <= overrun_set | (overrun    & ~err_clr);
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: one instance without parity, one with even parity.
module tb_uart_rx_fifo;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx = 1'b1;
  logic       rx_p = 1'b1;
  logic       rd_en = 1'b0;
  logic       rd_en_p = 1'b0;
  logic       err_clr = 1'b0;
  logic       err_clr_p = 1'b0;
  logic [7:0] cmd, cmd_p;
  logic       rdy, frame_err, parity_err, overrun;
  logic       rdy_p, frame_err_p, parity_err_p, overrun_p;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  uart_rx_fifo #(
    .CLK_PER_BIT (CPB), .DATA_BITS (8), .PARITY_EN (0), .PARITY_ODD (0), .FIFO_DEPTH (4)
  ) dut (
    .clk (clk), .rst (rst), .RX (rx), .rd_en (rd_en), .err_clr (err_clr),
    .cmd (cmd), .rdy (rdy), .frame_err (frame_err), .parity_err (parity_err), .overrun (overrun)
  );

  uart_rx_fifo #(
    .CLK_PER_BIT (CPB), .DATA_BITS (8), .PARITY_EN (1), .PARITY_ODD (0), .FIFO_DEPTH (4)
  ) dut_p (
    .clk (clk), .rst (rst), .RX (rx_p), .rd_en (rd_en_p), .err_clr (err_clr_p),
    .cmd (cmd_p), .rdy (rdy_p), .frame_err (frame_err_p), .parity_err (parity_err_p),
    .overrun (overrun_p)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic bit_out(input logic b, input bit on_p);
    if (on_p) rx_p = b;
    else      rx   = b;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] d, input bit on_p, input logic pbit, input logic stop_b);
    bit_out(1'b0, on_p);
    for (int i = 0; i < 8; i++) bit_out(d[i], on_p);
    if (on_p) bit_out(pbit, on_p);
    bit_out(stop_b, on_p);
    bit_out(1'b1, on_p);
  endtask

  task automatic pop_a();
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
  endtask

  task automatic clr_a();
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_rdy", 32'(rdy), 32'd0);
    check("rst_cmd", 32'(cmd), 32'd0);
    check("rst_flags", {29'd0, frame_err, parity_err, overrun}, 32'd0);
    check("rst_state", 32'(dut.state), 32'(uart_pkg::IDLE));
    check("rst_rdy_p", 32'(rdy_p), 32'd0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // Two frames, FIFO order and first-word fall-through.
    send(8'hA5, 1'b0, 1'b0, 1'b1);
    send(8'h3C, 1'b0, 1'b0, 1'b1);
    check("fwft_rdy", 32'(rdy), 32'd1);
    check("fwft_a5", 32'(cmd), 32'hA5);
    pop_a();
    check("fwft_3c", 32'(cmd), 32'h3C);
    check("fwft_rdy2", 32'(rdy), 32'd1);
    pop_a();
    check("fwft_empty", 32'(rdy), 32'd0);
    pop_a();
    check("underflow_rdy", 32'(rdy), 32'd0);

    // Overflow: fifth frame dropped.
    for (int i = 1; i <= 5; i++) send(8'(i), 1'b0, 1'b0, 1'b1);
    check("ovr_set", 32'(overrun), 32'd1);
    clr_a();
    check("ovr_clr", 32'(overrun), 32'd0);
    for (int i = 1; i <= 4; i++) begin
      check("ovr_data", 32'(cmd), 32'(i));
      pop_a();
    end
    check("ovr_empty", 32'(rdy), 32'd0);

    // Framing error then a good frame.
    send(8'h55, 1'b0, 1'b0, 1'b0);
    check("ferr_set", 32'(frame_err), 32'd1);
    check("ferr_nopush", 32'(rdy), 32'd0);
    send(8'h66, 1'b0, 1'b0, 1'b1);
    check("ferr_next_rdy", 32'(rdy), 32'd1);
    check("ferr_next_cmd", 32'(cmd), 32'h66);
    pop_a();
    clr_a();
    check("ferr_clr", 32'(frame_err), 32'd0);

    // Short glitch is a false start.
    rx = 1'b0;
    repeat (CPB / 4) @(negedge clk);
    rx = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    check("glitch_rdy", 32'(rdy), 32'd0);
    check("glitch_flags", {29'd0, frame_err, parity_err, overrun}, 32'd0);
    check("glitch_state", 32'(dut.state), 32'(uart_pkg::IDLE));

    // Break: one frame error, no retrigger while the line stays low.
    rx = 1'b0;
    repeat (11 * CPB) @(negedge clk);
    check("brk_ferr", 32'(frame_err), 32'd1);
    check("brk_rdy", 32'(rdy), 32'd0);
    clr_a();
    repeat (12 * CPB) @(negedge clk);
    check("brk_once", 32'(frame_err), 32'd0);
    rx = 1'b1;
    repeat (2 * CPB) @(negedge clk);

    // Reset in the middle of 0xFF, then a clean 0x12.
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
    repeat (3 * CPB + CPB / 2) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("mid_rst_state", 32'(dut.state), 32'(uart_pkg::IDLE));
    rst = 1'b0;
    repeat (8 * CPB) @(negedge clk);
    check("mid_rst_nopush", 32'(rdy), 32'd0);
    send(8'h12, 1'b0, 1'b0, 1'b1);
    check("mid_rst_cmd", 32'(cmd), 32'h12);
    check("mid_rst_flags", {29'd0, frame_err, parity_err, overrun}, 32'd0);
    pop_a();
    check("mid_rst_empty", 32'(rdy), 32'd0);

    // Even parity: 0x07 has three ones, so the correct parity bit is 1.
    send(8'h07, 1'b1, 1'b0, 1'b1);
    check("par_err", 32'(parity_err_p), 32'd1);
    check("par_nopush", 32'(rdy_p), 32'd0);
    send(8'h07, 1'b1, 1'b1, 1'b1);
    check("par_ok_rdy", 32'(rdy_p), 32'd1);
    check("par_ok_cmd", 32'(cmd_p), 32'h07);
    check("par_other", {30'd0, frame_err_p, overrun_p}, 32'd0);
    err_clr_p = 1'b1;
    rd_en_p = 1'b1;
    @(negedge clk);
    err_clr_p = 1'b0;
    rd_en_p = 1'b0;
    check("par_clr", 32'(parity_err_p), 32'd0);
    check("par_empty", 32'(rdy_p), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 The block SHALL have parameter CLK_PER_BIT, default 2604, meaning clk cycles per bit (legal range 16..4095).
REQ-002 The block SHALL have parameter DATA_BITS, default 8, meaning payload bits per frame (legal range 5..9).
REQ-003 The block SHALL have parameter PARITY_EN, default 0, meaning 1 = one parity bit follows the data bits.
REQ-004 The block SHALL have parameter PARITY_ODD, default 0, meaning 1 = odd parity and 0 = even parity; it is ignored when PARITY_EN=0.
REQ-005 The block SHALL have parameter FIFO_DEPTH, default 4, meaning the number of receive FIFO entries (power of 2, range 2..16).
REQ-006 clk  input  1  sole clock; the block SHALL use one clock, with all state updated on the rising edge.
REQ-007 rst  input  1  reset; reset SHALL be asynchronous and active-high.
REQ-008 RX  input  1  asynchronous serial line; idle level is high.
REQ-009 rd_en  input  1  pops the FIFO head when rdy=1.
REQ-010 err_clr  input  1  clears all sticky error flags.
REQ-011 cmd  output  DATA_BITS  FIFO head data (first-word fall-through); valid only while rdy=1.
REQ-012 rdy  output  1  FIFO non-empty.
REQ-013 frame_err  output  1  sticky flag: a stop bit was sampled low.
REQ-014 parity_err  output  1  sticky flag: a parity mismatch occurred.
REQ-015 overrun  output  1  sticky flag: a good frame was dropped because the FIFO was full.

Function
REQ-016 RX SHALL pass through a 2-flop synchronizer whose flops reset to 1; all sampling SHALL use the synchronized value rxs.
REQ-017 The FSM SHALL have states IDLE, START, DATA, PARITY, STOP.
REQ-018 IDLE→START SHALL occur on an rxs 1→0 edge; the baud counter SHALL be cleared on the same edge.
REQ-019 START SHALL sample rxs at count CLK_PER_BIT/2-1: if rxs=1, the FSM SHALL return to IDLE (false start) with no flag; otherwise it SHALL go to DATA and clear the counter.
REQ-020 DATA SHALL sample rxs at each count CLK_PER_BIT-1 and shift it in LSB-first; after DATA_BITS samples the FSM SHALL go to PARITY when PARITY_EN=1, else to STOP.
REQ-021 PARITY SHALL sample one bit at count CLK_PER_BIT-1; the sampled bit SHALL make total ones odd when PARITY_ODD=1, even otherwise.
REQ-022 STOP SHALL sample rxs at count CLK_PER_BIT-1 and then go to IDLE.
REQ-023 Stop=0 SHALL set frame_err and discard the frame.
REQ-024 Stop=1 with a parity mismatch SHALL set parity_err and discard the frame.
REQ-025 Otherwise the frame SHALL be pushed to the FIFO if it is not full; if the FIFO is full, the frame SHALL be dropped and overrun set.
REQ-026 rdy and cmd SHALL update on the cycle after the stop-bit sample edge, a latency of 1 clk.
REQ-027 rd_en with rdy=0 SHALL be ignored; there SHALL be no pointer underflow.
REQ-028 A simultaneous push and pop on a full FIFO SHALL accept the push with no overrun.
REQ-029 A simultaneous push and pop on an empty FIFO SHALL leave the new frame at the head with rdy=1.
REQ-030 FIFO pointers SHALL be log2(FIFO_DEPTH)+1 bits and wrap naturally; full and empty SHALL be derived from the MSB compare.
REQ-031 When err_clr and a new error set occur in the same cycle, set SHALL win.
REQ-032 The baud counter SHALL be $clog2(CLK_PER_BIT) bits and SHALL never exceed CLK_PER_BIT-1.
REQ-033 A frame that is low throughout (break) SHALL produce frame_err once and then require an rxs 1→0 edge before the next frame.

Reset
REQ-034 While rst=1, the block SHALL hold: FSM=IDLE, counters=0, shift register=0, FIFO pointers=0, rdy=0, cmd=0, all error flags=0, synchronizer flops=1.
REQ-035 Reset asserted mid-frame SHALL abort the frame with no push and no flag.
REQ-036 After rst falls, the block SHALL wait for an rxs 1→0 edge before starting a frame.

Structure
REQ-037 Package uart_pkg SHALL hold typedef enum rx_state_t {IDLE, START, DATA, PARITY, STOP} and the default CLK_PER_BIT constant shared with the transmitter.
REQ-038 The FIFO SHALL be a sub-module sync_fifo (params WIDTH, DEPTH; ports clk, rst, push, pop, din, dout, full, empty), instantiated once.

Verification
REQ-039 Default parameters, send 0xA5 then 0x3C, no rd_en → rdy=1, cmd=0xA5; rd_en pulse → cmd=0x3C; second rd_en → rdy=0.
REQ-040 Five frames 0x01..0x05 with FIFO_DEPTH=4, no reads → FIFO holds 0x01..0x04, overrun=1; err_clr → overrun=0.
REQ-041 Stop bit driven low on 0x55 → frame_err=1, rdy stays 0; following 0x66 with a good stop → rdy=1, cmd=0x66.
REQ-042 PARITY_EN=1, PARITY_ODD=0, send 0x07 with parity bit 0 → parity_err=1, nothing pushed; resend with parity 1 → cmd=0x07.
REQ-043 RX low pulse of CLK_PER_BIT/4 clks → no push, no flags, FSM back in IDLE.
REQ-044 rst asserted at data bit 3 of 0xFF, then a full 0x12 frame → only 0x12 appears in the FIFO, all flags 0.
